ila_tx_cmd_capture: RTL and testbench
=====================================

Name: ila_tx_cmd_capture

Overview:
Debug capture core for the TLK2711 TX command controller. It samples 15 probe signals every clock into a circular sample buffer, arms on request and triggers on a masked OR of the single-bit probes. It keeps a fixed pre-/post-trigger window that can be read back through a synchronous read port. It has no effect on the observed logic.

Parameters:
DEPTH, 1024, sample buffer depth; power of two, ≥4.
POST_TRIG, 512, samples kept from the trigger sample onward (trigger sample included); 1 ≤ POST_TRIG ≤ DEPTH.
PRE_TRIG (localparam), DEPTH-POST_TRIG, samples kept before the trigger.
AW (localparam), log2(DEPTH).

Ports:
clk  in  1  single clock for capture and readout.
rst  in  1  synchronous, active-high reset.
probe0  in  1  rd_cmd_ack.
probe1  in  1  rd_cmd_req.
probe2  in  48  rd_cmd_data.
probe3  in  1  dma_rd_last.
probe4  in  1  tx_start.
probe5  in  32  tx_base_addr.
probe6 / probe7 / probe8 / probe9  in  16 each  packet_body, packet_tail, body_num, frame_cnt.
probe10  in  1  internal rd_cmd_req.
probe11 / probe12  in  16 each  body_align8, tail_align8.
probe13  in  32  rd_addr.
probe14  in  16  rd_bbt.
i_arm  in  1  pulse; starts or restarts a capture.
i_trig_en  in  5  trigger enables for {probe10, probe4, probe3, probe1, probe0} (bit0 = probe0).
i_rd_addr  in  AW  logical readout index, 0 = oldest sample.
o_rd_data  out  229  sample at i_rd_addr.
o_armed  out  1  high in FILL, WAIT_TRIG and POST.
o_triggered  out  1  high in POST and DONE.
o_done  out  1  high in DONE.
o_trig_ptr  out  AW  physical buffer address of the trigger sample.

Behaviour:
- Sample packing, LSB first:
  - probe0 [0], probe1 [1], probe2 [49:2], probe3 [50], probe4 [51], probe5 [83:52]
  - probe6 [99:84], probe7 [115:100], probe8 [131:116], probe9 [147:132], probe10 [148]
  - probe11 [164:149], probe12 [180:165], probe13 [212:181], probe14 [228:213]
- States:
  - IDLE: no writes.
  - FILL: write every cycle; after PRE_TRIG writes, go to WAIT_TRIG.
  - WAIT_TRIG: write every cycle; on a trigger, go to POST.
  - POST: write until POST_TRIG total samples (trigger sample included) are written, then go to DONE.
  - DONE: no writes; holds until the next i_arm.
- The write pointer increments modulo DEPTH on each write.
- i_arm is registered. The first write occurs on the cycle after the i_arm cycle, and the state goes to FILL (or straight to WAIT_TRIG if PRE_TRIG=0). The write pointer is reset to 0 on arm.
- Trigger condition, evaluated on the same-cycle probes being written: (|(i_trig_en & {probe10,probe4,probe3,probe1,probe0})) or (i_trig_en==0).
- Triggers are ignored in FILL, so the pre-trigger window always holds valid data.
- On the trigger cycle, o_trig_ptr latches the write address. If POST_TRIG=1, go directly to DONE.
- i_arm in any state (including mid-capture) restarts the capture: pointer reset, flags cleared.
- Readout: o_rd_data is registered with 1-cycle latency and returns mem[(o_trig_ptr - PRE_TRIG + i_rd_addr) mod DEPTH]. The trigger sample is at index PRE_TRIG. Readout is valid only when o_done=1 and is undefined otherwise.
- Reset: state IDLE; o_armed, o_triggered, o_done = 0; o_trig_ptr = 0; o_rd_data = 0; write pointer = 0. Memory contents are not reset.
- Reset has priority over i_arm.
- Buffer: simple dual-port RAM, inferable as BRAM.

Decomposition:
- Package ila_tx_cmd_pkg holds:
  - SAMPLE_W = 229
  - per-probe bit-offset constants
  - state enum {IDLE, FILL, WAIT_TRIG, POST, DONE}
- One sub-module: ila_sdp_ram (parameters DEPTH and width; one write port, one registered read port).

Test Plan:
- Reset, DEPTH=16, POST_TRIG=8: assert rst for 2 cycles -> o_armed=0, o_triggered=0, o_done=0, o_trig_ptr=0, o_rd_data=0.
- Arm with i_trig_en=0: the trigger fires on the 9th write (first WAIT_TRIG cycle) -> o_done after 16 writes; o_trig_ptr=8; index 8 equals the sample taken 9 cycles after arm.
- Trigger on probe3 (i_trig_en=5'b00100): pulse probe3 at cycle 3 after arm (during FILL) and again at cycle 20 -> the first pulse is ignored; the trigger sample has bit[50]=1; probe5=32'h1000_0000 at trigger reads back at [83:52].
- Wrap-around: trigger at write 30 -> o_trig_ptr=(30-1) mod 16=13; logical readout 0..15 is contiguous in time with no gaps.
- Re-arm mid-POST -> flags clear, o_triggered=0; the new capture completes normally.
- POST_TRIG=16 (PRE_TRIG=0) and POST_TRIG=1: capture goes straight to WAIT_TRIG or straight to DONE; a probe0 trigger gives the trigger sample at index 0 or index 15 respectively.

Source files
------------

// File: rtl/ila_tx_cmd_pkg.sv
// Shared definitions for the TLK2711 TX command ILA: sample layout and capture states.
package ila_tx_cmd_pkg;

  localparam int unsigned SAMPLE_W = 229;

  // LSB positions of each probe inside a packed sample
  localparam int unsigned P0_LSB  = 0;
  localparam int unsigned P1_LSB  = 1;
  localparam int unsigned P2_LSB  = 2;
  localparam int unsigned P3_LSB  = 50;
  localparam int unsigned P4_LSB  = 51;
  localparam int unsigned P5_LSB  = 52;
  localparam int unsigned P6_LSB  = 84;
  localparam int unsigned P7_LSB  = 100;
  localparam int unsigned P8_LSB  = 116;
  localparam int unsigned P9_LSB  = 132;
  localparam int unsigned P10_LSB = 148;
  localparam int unsigned P11_LSB = 149;
  localparam int unsigned P12_LSB = 165;
  localparam int unsigned P13_LSB = 181;
  localparam int unsigned P14_LSB = 213;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/ila_sdp_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module ila_sdp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 229,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array itself stays uninitialised
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/ila_tx_cmd_capture.sv
// Debug capture core for the TLK2711 TX command controller: circular sample
// buffer with armed pre/post-trigger window and synchronous readout.
module ila_tx_cmd_capture
  import ila_tx_cmd_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned POST_TRIG = 512,
  localparam int unsigned PRE_TRIG = DEPTH - POST_TRIG,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                probe0,
  input  logic                probe1,
  input  logic [47:0]         probe2,
  input  logic                probe3,
  input  logic                probe4,
  input  logic [31:0]         probe5,
  input  logic [15:0]         probe6,
  input  logic [15:0]         probe7,
  input  logic [15:0]         probe8,
  input  logic [15:0]         probe9,
  input  logic                probe10,
  input  logic [15:0]         probe11,
  input  logic [15:0]         probe12,
  input  logic [31:0]         probe13,
  input  logic [15:0]         probe14,
  input  logic                i_arm,
  input  logic [4:0]          i_trig_en,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [SAMPLE_W-1:0] o_rd_data,
  output logic                o_armed,
  output logic                o_triggered,
  output logic                o_done,
  output logic [AW-1:0]       o_trig_ptr
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_TRIG - 1);

  cap_state_t          state, state_nxt;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       cnt;
  logic                we;
  logic                trig_hit;
  logic [SAMPLE_W-1:0] sample;
  logic [AW-1:0]       rd_phys;
  logic [4:0]          trig_vec;

  assign sample = {probe14, probe13, probe12, probe11, probe10, probe9, probe8,
                   probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};

  assign trig_vec = {probe10, probe4, probe3, probe1, probe0};
  assign trig_hit = (|(i_trig_en & trig_vec)) || (i_trig_en == '0);

  // Logical index 0 is the oldest sample of the window
  assign rd_phys = o_trig_ptr - AW'(PRE_TRIG) + i_rd_addr;

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    case (state)
      FILL: begin
        we = 1'b1;
        if (cnt == PRE_LAST) state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        we = 1'b1;
        if (trig_hit) state_nxt = (POST_TRIG == 1) ? DONE : POST;
      end
      POST: begin
        we = 1'b1;
        if (cnt == POST_LAST) state_nxt = DONE;
      end
      default: ;
    endcase
    // Arm restarts from any state; the arm cycle itself never writes
    if (i_arm) begin
      we        = 1'b0;
      state_nxt = (PRE_TRIG == 0) ? WAIT_TRIG : FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      cnt         <= '0;
      o_trig_ptr  <= '0;
      o_armed     <= 1'b0;
      o_triggered <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_armed     <= (state_nxt == FILL) || (state_nxt == WAIT_TRIG) || (state_nxt == POST);
      o_triggered <= (state_nxt == POST) || (state_nxt == DONE);
      o_done      <= (state_nxt == DONE);
      if (i_arm) begin
        wr_ptr <= '0;
        cnt    <= '0;
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        // cnt counts pre-trigger writes in FILL, then restarts at the trigger sample
        if (state == WAIT_TRIG && trig_hit) begin
          o_trig_ptr <= wr_ptr;
          cnt        <= CW'(1);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  ila_sdp_ram #(
    .DEPTH(DEPTH),
    .WIDTH(SAMPLE_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(sample),
    .raddr(rd_phys),
    .rdata(o_rd_data)
  );

endmodule

// File: tb/tb_ila_tx_cmd_capture.sv
// Directed bench for ila_tx_cmd_capture with three window configurations on DEPTH=16.
module tb_ila_tx_cmd_capture;

  localparam int unsigned SW = 229;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        probe0 = 1'b0, probe1 = 1'b0, probe3 = 1'b0, probe4 = 1'b0, probe10 = 1'b0;
  logic [47:0] probe2 = '0;
  logic [31:0] probe5 = '0, probe13 = '0;
  logic [15:0] probe6 = '0, probe7 = '0, probe8 = '0, probe9 = '0;
  logic [15:0] probe11 = '0, probe12 = '0, probe14 = '0;
  logic [3:0]  rd_addr = '0;

  logic        a_arm = 1'b0, b_arm = 1'b0, c_arm = 1'b0;
  logic [4:0]  a_en = '0, b_en = '0, c_en = '0;
  logic [SW-1:0] a_rd, b_rd, c_rd;
  logic        a_armed, a_trig, a_done, b_armed, b_trig, b_done, c_armed, c_trig, c_done;
  logic [3:0]  a_tp, b_tp, c_tp;

  logic [SW-1:0] hist [0:63];
  logic [SW-1:0] exp_q [$];
  int cyc = 0;
  int n_checks = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  ila_tx_cmd_capture #(.DEPTH(16), .POST_TRIG(8)) dut_a (
    .clk(clk), .rst(rst), .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
    .probe4(probe4), .probe5(probe5), .probe6(probe6), .probe7(probe7), .probe8(probe8),
    .probe9(probe9), .probe10(probe10), .probe11(probe11), .probe12(probe12),
    .probe13(probe13), .probe14(probe14), .i_arm(a_arm), .i_trig_en(a_en),
    .i_rd_addr(rd_addr), .o_rd_data(a_rd), .o_armed(a_armed), .o_triggered(a_trig),
    .o_done(a_done), .o_trig_ptr(a_tp));

  ila_tx_cmd_capture #(.DEPTH(16), .POST_TRIG(16)) dut_b (
    .clk(clk), .rst(rst), .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
    .probe4(probe4), .probe5(probe5), .probe6(probe6), .probe7(probe7), .probe8(probe8),
    .probe9(probe9), .probe10(probe10), .probe11(probe11), .probe12(probe12),
    .probe13(probe13), .probe14(probe14), .i_arm(b_arm), .i_trig_en(b_en),
    .i_rd_addr(rd_addr), .o_rd_data(b_rd), .o_armed(b_armed), .o_triggered(b_trig),
    .o_done(b_done), .o_trig_ptr(b_tp));

  ila_tx_cmd_capture #(.DEPTH(16), .POST_TRIG(1)) dut_c (
    .clk(clk), .rst(rst), .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
    .probe4(probe4), .probe5(probe5), .probe6(probe6), .probe7(probe7), .probe8(probe8),
    .probe9(probe9), .probe10(probe10), .probe11(probe11), .probe12(probe12),
    .probe13(probe13), .probe14(probe14), .i_arm(c_arm), .i_trig_en(c_en),
    .i_rd_addr(rd_addr), .o_rd_data(c_rd), .o_armed(c_armed), .o_triggered(c_trig),
    .o_done(c_done), .o_trig_ptr(c_tp));

  function automatic logic [SW-1:0] pack_probes();
    return {probe14, probe13, probe12, probe11, probe10, probe9, probe8, probe7,
            probe6, probe5, probe4, probe3, probe2, probe1, probe0};
  endfunction

  function automatic logic [SW-1:0] rd_sel(input int w);
    if (w == 0) return a_rd;
    if (w == 1) return b_rd;
    return c_rd;
  endfunction

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_data();
    probe1  = 1'($urandom);
    probe4  = 1'($urandom);
    probe10 = 1'($urandom);
    probe2  = {16'($urandom), $urandom};
    probe5  = $urandom;
    probe6  = 16'($urandom);
    probe7  = 16'($urandom);
    probe8  = 16'($urandom);
    probe9  = 16'($urandom);
    probe11 = 16'($urandom);
    probe12 = 16'($urandom);
    probe13 = $urandom;
    probe14 = 16'($urandom);
  endtask

  // One capture cycle: drive probes, record the sample as write number cyc
  task automatic tick(input logic p0v, input logic p3v, input logic [31:0] p5v, input bit p5_force);
    randomize_data();
    probe0 = p0v;
    probe3 = p3v;
    if (p5_force) probe5 = p5v;
    cyc++;
    hist[cyc] = pack_probes();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int w, input logic [4:0] en);
    randomize_data();
    probe0 = 1'b0;
    probe3 = 1'b0;
    case (w)
      0: begin a_arm = 1'b1; a_en = en; end
      1: begin b_arm = 1'b1; b_en = en; end
      default: begin c_arm = 1'b1; c_en = en; end
    endcase
    @(posedge clk);
    #1;
    a_arm = 1'b0;
    b_arm = 1'b0;
    c_arm = 1'b0;
    cyc = 0;
  endtask

  task automatic read_all(input int w, input int first_w);
    for (int j = 0; j < 16; j++) begin
      exp_q.push_back(hist[first_w + j]);
      rd_addr = 4'(j);
      @(posedge clk);
      #1;
      check($sformatf("rd%0d_idx%0d", w, j), rd_sel(w), exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] s;
    repeat (2) @(posedge clk);
    #1;
    check("rst_armed", a_armed, 0);
    check("rst_trig", a_trig, 0);
    check("rst_done", a_done, 0);
    check("rst_tp", a_tp, 0);
    check("rst_rd", a_rd, 0);
    check("rst_rd_c", c_rd, 0);
    rst = 1'b0;

    // Free-running trigger: fires on write 9, the first WAIT_TRIG cycle
    arm(0, 5'b00000);
    check("a1_armed", a_armed, 1);
    check("a1_done0", a_done, 0);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 1'b0, '0, 1'b0);
      if (k == 8)  check("a1_trig_pre", a_trig, 0);
      if (k == 9)  check("a1_trig", a_trig, 1);
      if (k == 15) check("a1_done_early", a_done, 0);
    end
    check("a1_done", a_done, 1);
    check("a1_armed_off", a_armed, 0);
    check("a1_tp", a_tp, 8);
    read_all(0, 1);

    // probe3 trigger; the FILL-time pulse must be ignored
    arm(0, 5'b00100);
    for (int k = 1; k <= 27; k++) begin
      tick(1'b0, (k == 3 || k == 20), 32'h1000_0000, k == 20);
      if (k == 3)  check("a2_fill_ignored", a_trig, 0);
      if (k == 19) check("a2_wait", a_trig, 0);
      if (k == 20) check("a2_trig", a_trig, 1);
      if (k == 26) check("a2_done_early", a_done, 0);
    end
    check("a2_done", a_done, 1);
    check("a2_tp", a_tp, 3);
    rd_addr = 4'd8;
    @(posedge clk);
    #1;
    s = a_rd;
    check("a2_bit50", s[50], 1);
    check("a2_p5", s[83:52], 32'h1000_0000);
    read_all(0, 12);

    // Wrap-around: trigger on write 30
    arm(0, 5'b00100);
    for (int k = 1; k <= 37; k++) tick(1'b0, k == 30, '0, 1'b0);
    check("a3_done", a_done, 1);
    check("a3_tp", a_tp, 13);
    read_all(0, 22);

    // Re-arm while in POST
    arm(0, 5'b00000);
    for (int k = 1; k <= 11; k++) tick(1'b0, 1'b0, '0, 1'b0);
    check("a4_trig_mid", a_trig, 1);
    arm(0, 5'b00000);
    check("a4_rearm_trig", a_trig, 0);
    check("a4_rearm_armed", a_armed, 1);
    check("a4_rearm_done", a_done, 0);
    for (int k = 1; k <= 16; k++) tick(1'b0, 1'b0, '0, 1'b0);
    check("a4_done", a_done, 1);
    check("a4_tp", a_tp, 8);
    read_all(0, 1);

    // PRE_TRIG=0: straight to WAIT_TRIG, trigger sample at index 0
    arm(1, 5'b00001);
    check("b_armed", b_armed, 1);
    for (int k = 1; k <= 20; k++) begin
      tick(k == 5, 1'b0, '0, 1'b0);
      if (k == 4)  check("b_wait", b_trig, 0);
      if (k == 5)  check("b_trig", b_trig, 1);
      if (k == 19) check("b_done_early", b_done, 0);
    end
    check("b_done", b_done, 1);
    check("b_tp", b_tp, 4);
    read_all(1, 5);

    // POST_TRIG=1: trigger goes straight to DONE, trigger sample at index 15
    arm(2, 5'b00001);
    for (int k = 1; k <= 20; k++) begin
      tick(k == 10 || k == 20, 1'b0, '0, 1'b0);
      if (k == 10) check("c_fill_ignored", c_trig, 0);
      if (k == 19) check("c_armed_wait", c_armed, 1);
    end
    check("c_done", c_done, 1);
    check("c_trig", c_trig, 1);
    check("c_armed_off", c_armed, 0);
    check("c_tp", c_tp, 3);
    read_all(2, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
